// File: rtl/fb_rect_fill_if.sv
// Command, grant and pixel-write bundle between a rectangle-fill engine and its neighbours.
// master: command/grant source; slave: the fill engine.
interface fb_rect_fill_if #(
    parameter int unsigned AW = 19,
    parameter int unsigned DW = 16
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [9:0]    cmd_x;
    logic [8:0]    cmd_y;
    logic [9:0]    cmd_w;
    logic [8:0]    cmd_h;
    logic [DW-1:0] cmd_color;
    logic          en;
    logic [AW-1:0] addr;
    logic [DW-1:0] dwrite;
    logic          wr;
    logic          busy;
    logic          done;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, en,
        input  cmd_ready, addr, dwrite, wr, busy, done
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, en,
        output cmd_ready, addr, dwrite, wr, busy, done
    );
endinterface

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: expands one fill command into row-major single-pixel framebuffer writes.
// Define FB_FILL_CLIP_EN to clip the rectangle to the visible H_RES x V_RES frame.
module fb_rect_fill #(
    parameter int unsigned H_RES = 640,
    parameter int unsigned V_RES = 480,
    parameter int unsigned AW    = 19,
    parameter int unsigned DW    = 16
) (
    input logic           clk,
    input logic           rst,
    fb_rect_fill_if.slave fb
);
    localparam int unsigned XW = 10;
    localparam int unsigned YW = 9;

    typedef enum logic [1:0] {S_IDLE, S_SETUP, S_FILL, S_DONE} state_t;

    if (H_RES == 0 || V_RES == 0) begin : g_bad_cfg
        $error("fb_rect_fill: H_RES and V_RES must be nonzero");
    end

    state_t        r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [XW-1:0] r_w;
    logic [YW-1:0] r_h;
    logic [DW-1:0] r_color;
    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic [AW-1:0] r_row_base;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_dwrite;
    logic          r_wr;
    logic          r_busy;
    logic          r_done;

    logic [XW-1:0] w_w_eff;
    logic [YW-1:0] w_h_eff;
    logic          w_col_last;
    logic          w_row_last;

    // Effective rectangle size, evaluated in SETUP from the captured command.
`ifdef FB_FILL_CLIP_EN
    always_comb begin
        w_w_eff = r_w;
        w_h_eff = r_h;
        if (32'(r_x) >= H_RES || 32'(r_y) >= V_RES) begin
            w_w_eff = '0;
            w_h_eff = '0;
        end else begin
            if (32'(r_w) > H_RES - 32'(r_x)) w_w_eff = XW'(H_RES - 32'(r_x));
            if (32'(r_h) > V_RES - 32'(r_y)) w_h_eff = YW'(V_RES - 32'(r_y));
        end
    end
`else
    assign w_w_eff = r_w;
    assign w_h_eff = r_h;
`endif

    assign w_col_last = (r_col == r_w - XW'(1));
    assign w_row_last = (r_row == r_h - YW'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_x        <= '0;
            r_y        <= '0;
            r_w        <= '0;
            r_h        <= '0;
            r_color    <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
            r_addr     <= '0;
            r_dwrite   <= '0;
            r_wr       <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_wr   <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (fb.cmd_valid) begin
                        r_x     <= fb.cmd_x;
                        r_y     <= fb.cmd_y;
                        r_w     <= fb.cmd_w;
                        r_h     <= fb.cmd_h;
                        r_color <= fb.cmd_color;
                        r_busy  <= 1'b1;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    r_w        <= w_w_eff;
                    r_h        <= w_h_eff;
                    r_col      <= '0;
                    r_row      <= '0;
                    r_row_base <= AW'(r_y) * AW'(H_RES);
                    r_state    <= (w_w_eff != '0 && w_h_eff != '0) ? S_FILL : S_DONE;
                end
                S_FILL: begin
                    // A low grant holds position; addr/dwrite keep the last pixel.
                    if (fb.en) begin
                        r_wr     <= 1'b1;
                        r_addr   <= r_row_base + AW'(r_x) + AW'(r_col);
                        r_dwrite <= r_color;
                        if (w_col_last) begin
                            r_col      <= '0;
                            r_row      <= r_row + YW'(1);
                            r_row_base <= r_row_base + AW'(H_RES);
                            if (w_row_last) r_state <= S_DONE;
                        end else begin
                            r_col <= r_col + XW'(1);
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign fb.cmd_ready = (r_state == S_IDLE);
    assign fb.addr      = r_addr;
    assign fb.dwrite    = r_dwrite;
    assign fb.wr        = r_wr;
    assign fb.busy      = r_busy;
    assign fb.done      = r_done;
endmodule

// File: tb/tb_fb_rect_fill.sv
// Self-checking bench for fb_rect_fill: directed and random fills checked cycle by cycle
// against a pixel-list reference model (honours FB_FILL_CLIP_EN when defined).
module tb_fb_rect_fill;
    localparam int H_RES = 640;
    localparam int V_RES = 480;
    localparam int AW    = 19;
    localparam int DW    = 16;
    localparam int MAXK  = 400;

    logic clk     = 1'b0;
    logic clk_run = 1'b0;
    logic rst     = 1'b0;

    int n_checks = 0;
    int n_err    = 0;

    logic [AW-1:0] exp_addr = '0;
    logic [DW-1:0] exp_data = '0;
    int unsigned   pix_q[$];
    bit            en_pat[MAXK];

    fb_rect_fill_if #(.AW(AW), .DW(DW)) fb ();

    fb_rect_fill #(.H_RES(H_RES), .V_RES(V_RES), .AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
        .fb (fb)
    );

    always #5 if (clk_run) clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_checks++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    // Reference: the full list of pixel addresses the command must write, in order.
    task automatic build_pixels(input int x, input int y, input int w, input int h);
        int we;
        int he;
        pix_q.delete();
        we = w;
        he = h;
`ifdef FB_FILL_CLIP_EN
        if (x >= H_RES || y >= V_RES) begin
            we = 0;
            he = 0;
        end else begin
            if (we > H_RES - x) we = H_RES - x;
            if (he > V_RES - y) he = V_RES - y;
        end
`endif
        for (int r = 0; r < he; r++)
            for (int c = 0; c < we; c++)
                pix_q.push_back(int'(((y + r) * H_RES + x + c) % (1 << AW)));
    endtask

    task automatic en_all_high();
        for (int k = 0; k < MAXK; k++) en_pat[k] = 1'b1;
    endtask

    task automatic en_random();
        for (int k = 0; k < MAXK; k++) en_pat[k] = (k >= 300) || ($urandom_range(3, 0) != 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "/wr"},     32'(fb.wr),        32'd0);
        chk({name, "/addr"},   32'(fb.addr),      32'd0);
        chk({name, "/dwrite"}, 32'(fb.dwrite),    32'd0);
        chk({name, "/done"},   32'(fb.done),      32'd0);
        chk({name, "/busy"},   32'(fb.busy),      32'd0);
        chk({name, "/ready"},  32'(fb.cmd_ready), 32'd1);
    endtask

    // Issue one command at the next edge and check every cycle until its done pulse.
    // abort_k > 0 raises rst asynchronously after edge abort_k instead of finishing.
    task automatic run_cmd(input string name, input int x, input int y, input int w, input int h,
                           input logic [DW-1:0] color, input int abort_k);
        int n;
        int issued;
        int last_k;
        int done_k;
        int kv;
        int cnt;
        bit issue;
        build_pixels(x, y, w, h);
        n = pix_q.size();
        issued = 0;
        last_k = 1;
        for (int k = 2; k < MAXK && issued < n; k++)
            if (en_pat[k]) begin
                issued++;
                last_k = k;
            end
        chk({name, "/schedule"}, 32'(issued), 32'(n));
        done_k = last_k + 1;
        kv = (abort_k > 0) ? 5 : int'($urandom_range(done_k - 1, 1));

        @(negedge clk);
        chk({name, "/ready_at_issue"}, 32'(fb.cmd_ready), 32'd1);
        fb.cmd_valid = 1'b1;
        fb.cmd_x     = 10'(x);
        fb.cmd_y     = 9'(y);
        fb.cmd_w     = 10'(w);
        fb.cmd_h     = 9'(h);
        fb.cmd_color = color;
        fb.en        = en_pat[0];
        @(posedge clk);
        cnt = 0;
        for (int k = 1; k <= done_k; k++) begin
            @(negedge clk);
            fb.cmd_valid = (k == kv);
            fb.cmd_x     = 10'($urandom);
            fb.cmd_y     = 9'($urandom);
            fb.cmd_w     = 10'($urandom);
            fb.cmd_h     = 9'($urandom);
            fb.cmd_color = 16'($urandom);
            fb.en        = en_pat[k];
            if (k == abort_k) begin
                @(posedge clk);
                #2 rst = 1'b1;
                #1 chk_reset_outputs({name, "/async_rst"});
                exp_addr = '0;
                exp_data = '0;
                @(negedge clk);
                rst          = 1'b0;
                fb.cmd_valid = 1'b0;
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    chk({name, "/post_rst_wr"},   32'(fb.wr),   32'd0);
                    chk({name, "/post_rst_done"}, 32'(fb.done), 32'd0);
                    chk({name, "/post_rst_busy"}, 32'(fb.busy), 32'd0);
                end
                return;
            end
            @(posedge clk);
            #1;
            issue = (k >= 2) && (cnt < n) && en_pat[k];
            if (issue) begin
                exp_addr = AW'(pix_q[cnt]);
                exp_data = color;
                cnt++;
            end
            chk({name, "/wr"},     32'(fb.wr),        32'(issue));
            chk({name, "/addr"},   32'(fb.addr),      32'(exp_addr));
            chk({name, "/dwrite"}, 32'(fb.dwrite),    32'(exp_data));
            chk({name, "/done"},   32'(fb.done),      32'(k == done_k));
            chk({name, "/busy"},   32'(fb.busy),      32'(k < done_k));
            chk({name, "/ready"},  32'(fb.cmd_ready), 32'(k == done_k));
        end
    endtask

    initial begin
        int rx;
        int ry;
        fb.cmd_valid = 1'b0;
        fb.cmd_x     = '0;
        fb.cmd_y     = '0;
        fb.cmd_w     = '0;
        fb.cmd_h     = '0;
        fb.cmd_color = '0;
        fb.en        = 1'b0;

        // Reset with the clock stopped.
        #2 rst = 1'b1;
        #1 chk_reset_outputs("reset");
        clk_run = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        en_all_high();
        run_cmd("basic", 2, 1, 3, 2, 16'hF800, 0);

        en_all_high();
        en_pat[4] = 1'b0;
        en_pat[5] = 1'b0;
        run_cmd("stall", 2, 1, 3, 2, 16'hF800, 0);

        en_all_high();
        run_cmd("zero_w", 10, 10, 0, 5, 16'h07E0, 0);
        run_cmd("zero_h", 10, 10, 5, 0, 16'h001F, 0);

        en_all_high();
        run_cmd("edge", 638, 479, 4, 3, 16'h1234, 0);
        run_cmd("offframe", 700, 20, 3, 2, 16'h4321, 0);

        for (int i = 0; i < 20; i++) begin
            en_random();
            rx = ($urandom_range(1, 0) != 0) ? int'($urandom_range(1023, 0))
                                             : int'($urandom_range(H_RES + 10, H_RES - 10));
            ry = ($urandom_range(1, 0) != 0) ? int'($urandom_range(511, 0))
                                             : int'($urandom_range(V_RES + 10, V_RES - 10));
            run_cmd("random", rx, ry, int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                    16'($urandom), 0);
        end

        en_all_high();
        run_cmd("abort", 100, 50, 20, 2, 16'hAAAA, 10);
        en_random();
        run_cmd("after_abort", 5, 7, 4, 3, 16'h5555, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
